// File: rtl/shifter_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential shifter.
package shifter_pkg;

    localparam logic [1:0] OP_LL  = 2'b00;
    localparam logic [1:0] OP_RL  = 2'b10;
    localparam logic [1:0] OP_RA  = 2'b11;
    localparam logic [1:0] OP_RSV = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of the working value; the reserved opcode passes the
// value through so that an illegal request still runs its full latency.
module shift_step
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_value,
    input  logic [1:0]            i_op,
    output logic [DATA_WIDTH-1:0] o_value
);

    // Select the fill bit and direction for a single-bit shift.
    always_comb begin
        o_value = i_value;
        case (i_op)
            OP_LL:   o_value = {i_value[DATA_WIDTH-2:0], 1'b0};
            OP_RL:   o_value = {1'b0, i_value[DATA_WIDTH-1:1]};
            OP_RA:   o_value = {i_value[DATA_WIDTH-1], i_value[DATA_WIDTH-1:1]};
            default: o_value = i_value;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request, in_ready high
//   SHIFT | shifting one position per edge, count holds shifts left
//   DONE  | Result presented, held until out_ready handshake
//
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [SHAMT_WIDTH-1:0] B,
    input  logic [1:0]             Shiftop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  Result,
    output logic                   busy,
    output logic                   op_err
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_work;
    logic [DATA_WIDTH-1:0]  w_work_nxt;
    logic [DATA_WIDTH-1:0]  w_stepped;
    logic [SHAMT_WIDTH-1:0] r_count;
    logic [SHAMT_WIDTH-1:0] w_count_nxt;
    logic [1:0]             r_op;
    logic [1:0]             w_op_nxt;

    shift_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift_step (
        .i_value(r_work),
        .i_op   (r_op),
        .o_value(w_stepped)
    );

    // State, working value, count and latched opcode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_count <= '0;
            r_op    <= OP_LL;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_work_nxt  = A;
                    w_count_nxt = B;
                    w_op_nxt    = Shiftop;
                    w_state_nxt = (B == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy        = 1'b1;
                w_work_nxt  = w_stepped;
                w_count_nxt = r_count - SHAMT_WIDTH'(1);
                if (r_count == SHAMT_WIDTH'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign Result = r_work;
    // op_err only carries meaning alongside out_valid, so gate it there.
    assign op_err = out_valid && (r_op == OP_RSV);

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: behavioural reference (shift arithmetic plus a
// B+1-edge latency rule) checked every cycle, plus literal directed cases.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [4:0]  B;
    logic [1:0]  Shiftop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        busy;
    logic        op_err;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shifter #(
        .DATA_WIDTH (32),
        .SHAMT_WIDTH(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Shiftop  (Shiftop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Result   (Result),
        .busy     (busy),
        .op_err   (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout_fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endfunction

    // Reference result from plain arithmetic on the request fields.
    function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a, int b);
        case (op)
            2'b00:   return a << b;
            2'b10:   return a >> b;
            2'b11:   return 32'($signed(a) >>> b);
            default: return a;
        endcase
    endfunction

    // Behavioural model: a request is outstanding from its accept edge
    // (edge 1) and its result is visible once B+1 edges have elapsed.
    bit          m_active = 0;
    int          m_edges  = 0;
    int          m_b      = 0;
    logic [31:0] m_res    = '0;
    logic        m_err    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_edges  = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1;
                m_edges  = 1;
                m_b      = int'(B);
                m_res    = ref_shift(Shiftop, A, int'(B));
                m_err    = (Shiftop == 2'b01);
            end
        end else if (m_edges >= m_b + 1) begin
            if (out_ready) m_active = 0;
        end else begin
            m_edges++;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_v;
            exp_v = m_active && (m_edges >= m_b + 1);
            chk("mdl_in_ready", 32'(in_ready), 32'(!m_active));
            chk("mdl_busy", 32'(busy), 32'(m_active));
            chk("mdl_out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                chk("mdl_result", Result, m_res);
                chk("mdl_op_err", 32'(op_err), 32'(m_err));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout_fail("send_in_ready");
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Shiftop  = op;
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = 5'($urandom);
        Shiftop  = 2'($urandom);
    endtask

    task automatic run_directed(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [4:0] b, input logic [31:0] exp_res,
                                input int exp_lat, input logic exp_err, input int stall);
        int lat;
        int guard;
        out_ready = 1'b0;
        send(op, a, b);
        lat   = 1;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            lat++;
            guard++;
        end
        if (guard >= 100) timeout_fail({name, "_valid"});
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, Result, exp_res);
        chk({name, "_op_err"}, 32'(op_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            A        = $urandom;
            B        = 5'($urandom);
            Shiftop  = 2'($urandom);
            @(negedge clk);
            chk({name, "_stall_result"}, Result, exp_res);
            chk({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_release_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic rand_collect();
        int  guard;
        bit  done;
        guard = 0;
        done  = 0;
        while (!done && guard < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            done      = out_valid && out_ready;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (!done) timeout_fail("rand_handshake");
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Shiftop   = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_op_err", 32'(op_err), 32'd0);
        rst_n = 1'b1;

        run_directed("ll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 1'b0, 0);
        run_directed("rl4", 2'b10, 32'h8000_0000, 5'd4, 32'h0800_0000, 5, 1'b0, 0);
        run_directed("ra4neg", 2'b11, 32'hF000_0000, 5'd4, 32'hFF00_0000, 5, 1'b0, 0);
        run_directed("ra4pos", 2'b11, 32'h7000_0000, 5'd4, 32'h0700_0000, 5, 1'b0, 0);
        run_directed("b0_ll", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0, 0);
        run_directed("b0_rl", 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0, 0);
        run_directed("b0_ra", 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b0, 0);
        run_directed("b0_rsv", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b1, 0);
        run_directed("bp_ll8", 2'b00, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 9, 1'b0, 6);
        run_directed("rsv3", 2'b01, 32'h1234_5678, 5'd3, 32'h1234_5678, 4, 1'b1, 0);
        run_directed("ra1", 2'b11, 32'h8000_0001, 5'd1, 32'hC000_0000, 2, 1'b0, 2);

        // Asynchronous reset in the middle of a long arithmetic shift.
        send(2'b11, 32'h8000_0000, 5'd20);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 30; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            rand_collect();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
